rrp_mult_arbiter: RTL and testbench

RRP_MULT_ARBITER -- requirements
Module: rrp_mult_arbiter

---
 rtl/rrp_mult_arbiter.sv | 133 +++++++++++++
 tb/tb_rrp_mult_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rrp_mult_arbiter.sv
// rrp_mult_arbiter: two-way round-robin issue front end for a pipelined rRp_mult.
// Tags each accepted op, captures products in an in-order FIFO, and limits issue by credits.
//
// Ports:
//   clock, reset_n              clock, async active-low reset
//   reqN_valid/ready/x/y (N=0,1) requester operand handshake (digit-packed, MSD first)
//   mult_x, mult_y               registered operands to the multiplier
//   mult_p                       product from the multiplier (LAT edges after mult_x/y)
//   res_valid/ready/p/id         result FIFO head handshake, id = issuing requester
//   busy                         any op in flight or buffered
module rrp_mult_arbiter #(
    parameter  int WIDTH = 4,
    parameter  int RADIX = 4,
    parameter  int LAT   = 2,
    parameter  int DEPTH = 4,
    localparam int D     = $clog2(RADIX) + 1,
    localparam int PW    = D * (2 * WIDTH + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [D*WIDTH-1:0] req0_x,
    input  logic [D*WIDTH-1:0] req0_y,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [D*WIDTH-1:0] req1_x,
    input  logic [D*WIDTH-1:0] req1_y,
    output logic [D*WIDTH-1:0] mult_x,
    output logic [D*WIDTH-1:0] mult_y,
    input  logic [PW-1:0]      mult_p,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [PW-1:0]      res_p,
    output logic               res_id,
    output logic               busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ptr_q, ptr_d;
    logic [LAT:0]  tv_q;
    logic [LAT:0]  tid_q;
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   fcnt_q;
    logic [PW-1:0] mem_p  [DEPTH];
    logic          mem_id [DEPTH];

    logic full, acc0, acc1, acc, gid, wr, pop;

    // ptr_q == 1 means requester 1 wins the next tie.
    assign full       = (cnt_q == CW'(DEPTH));
    assign req0_ready = reset_n && !full && (!ptr_q || !req1_valid);
    assign req1_ready = reset_n && !full && (ptr_q || !req0_valid);
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;
    assign acc        = acc0 || acc1;
    assign gid        = acc1;

    // The tag leaving the last stage lines up with mult_p for that op.
    assign wr         = tv_q[LAT];
    assign res_valid  = (fcnt_q != '0);
    assign pop        = res_valid && res_ready;
    assign res_p      = res_valid ? mem_p[rp_q] : '0;
    assign res_id     = res_valid && mem_id[rp_q];
    assign busy       = (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (acc && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!acc && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (acc) begin
            ptr_d = !gid;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            ptr_q  <= 1'b0;
            tv_q   <= '0;
            tid_q  <= '0;
            mult_x <= '0;
            mult_y <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            tv_q   <= {tv_q[LAT-1:0], acc};
            tid_q  <= {tid_q[LAT-1:0], gid};
            if (acc) begin
                mult_x <= acc1 ? req1_x : req0_x;
                mult_y <= acc1 ? req1_y : req0_y;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp_q   <= '0;
            rp_q   <= '0;
            fcnt_q <= '0;
        end else begin
            if (wr) begin
                wp_q <= wp_q + AW'(1);
            end
            if (pop) begin
                rp_q <= rp_q + AW'(1);
            end
            if (wr && !pop) begin
                fcnt_q <= fcnt_q + (AW+1)'(1);
            end else if (!wr && pop) begin
                fcnt_q <= fcnt_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr) begin
            mem_p[wp_q]  <= mult_p;
            mem_id[wp_q] <= tid_q[LAT];
        end
    end

endmodule

// File: tb/tb_rrp_mult_arbiter.sv
// tb_rrp_mult_arbiter: table, directed and random checks of rrp_mult_arbiter
// against a queue-based arbiter/FIFO model and a value-level multiplier model.
module tb_rrp_mult_arbiter;

    localparam int W  = 4;
    localparam int R  = 4;
    localparam int L  = 2;
    localparam int DP = 4;
    localparam int D  = 3;
    localparam int XW = D * W;
    localparam int PW = D * (2 * W + 1);

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [XW-1:0] req0_x, req0_y, req1_x, req1_y;
    logic [XW-1:0] mult_x, mult_y;
    logic [PW-1:0] mult_p;
    logic          res_valid, res_ready, res_id, busy;
    logic [PW-1:0] res_p;

    always #5 clock = ~clock;

    rrp_mult_arbiter #(
        .WIDTH(W), .RADIX(R), .LAT(L), .DEPTH(DP)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_x(req1_x), .req1_y(req1_y),
        .mult_x(mult_x), .mult_y(mult_y), .mult_p(mult_p),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_p(res_p), .res_id(res_id), .busy(busy)
    );

    // Value-level golden multiplier: signed-digit value of each operand,
    // integer product, re-encoded as radix-R digits (top digit signed).
    function automatic logic [PW-1:0] gold(input logic [XW-1:0] x,
                                           input logic [XW-1:0] y);
        longint vx, vy, v, d;
        logic signed [D-1:0] dg;
        logic [PW-1:0] p;
        vx = 0;
        vy = 0;
        for (int i = W - 1; i >= 0; i--) begin
            dg = x[D*i +: D];
            vx = vx * R + dg;
            dg = y[D*i +: D];
            vy = vy * R + dg;
        end
        v = vx * vy;
        p = '0;
        for (int i = 0; i < 2 * W; i++) begin
            d = v % R;
            if (d < 0) d = d + R;
            p[D*i +: D] = d[D-1:0];
            v = (v - d) / R;
        end
        p[D*2*W +: D] = v[D-1:0];
        return p;
    endfunction

    // Multiplier with L register stages and no reset.
    logic [PW-1:0] mpipe [L];
    always @(posedge clock) begin
        mpipe[0] <= gold(mult_x, mult_y);
        for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mult_p = mpipe[L-1];

    typedef struct {
        logic [PW-1:0] p;
        logic          id;
        int            t;
    } ent_t;

    typedef struct {
        bit v0, v1, rr;
        bit r0, r1, rv, bz;
    } vec_t;

    ent_t q[$];
    bit   last;
    int   cyc;
    int   ntot;
    int   npass;
    bit   tbl_on;
    vec_t cur;
    vec_t tbl[17];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    // One clock: compare at negedge against the model, then advance it.
    task automatic step();
        bit g, acc, vis, pop, full;
        logic [XW-1:0] ax, ay;
        ent_t e;
        @(negedge clock);
        full = (q.size() == DP);
        if (req0_valid && req1_valid) g = ~last;
        else g = req1_valid;
        acc = (req0_valid || req1_valid) && !full;
        ax  = g ? req1_x : req0_x;
        ay  = g ? req1_y : req0_y;
        if (req0_valid) chk("ready0", req0_ready, acc && !g);
        if (req1_valid) chk("ready1", req1_ready, acc && g);
        vis = (q.size() > 0) && (cyc >= q[0].t);
        chk("res_valid", res_valid, vis);
        if (vis) begin
            chk("res_p", res_p, q[0].p);
            chk("res_id", res_id, q[0].id);
        end
        chk("busy", busy, q.size() != 0);
        if (tbl_on) begin
            if (cur.v0) chk("tbl_ready0", req0_ready, cur.r0);
            if (cur.v1) chk("tbl_ready1", req1_ready, cur.r1);
            chk("tbl_res_valid", res_valid, cur.rv);
            chk("tbl_busy", busy, cur.bz);
        end
        pop = vis && res_ready;
        @(posedge clock);
        #1;
        cyc++;
        if (pop) void'(q.pop_front());
        if (acc) begin
            e.p  = gold(ax, ay);
            e.id = g;
            e.t  = cyc + L + 1;
            q.push_back(e);
            last = g;
        end
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        q.delete();
        last = 1'b1;
    endtask

    int first;

    initial begin
        ntot   = 0;
        npass  = 0;
        cyc    = 0;
        tbl_on = 1'b0;
        last   = 1'b1;
        tbl[0]  = '{1,1,1, 1,0,0,0};
        tbl[1]  = '{1,1,1, 0,1,0,1};
        tbl[2]  = '{0,0,1, 0,0,0,1};
        tbl[3]  = '{0,0,1, 0,0,0,1};
        tbl[4]  = '{0,0,1, 0,0,1,1};
        tbl[5]  = '{0,0,1, 0,0,1,1};
        tbl[6]  = '{0,0,0, 0,0,0,0};
        tbl[7]  = '{1,1,0, 1,0,0,0};
        tbl[8]  = '{1,1,0, 0,1,0,1};
        tbl[9]  = '{1,1,0, 1,0,0,1};
        tbl[10] = '{1,1,0, 0,1,0,1};
        tbl[11] = '{1,1,0, 0,0,1,1};
        tbl[12] = '{1,1,1, 0,0,1,1};
        tbl[13] = '{1,1,1, 1,0,1,1};
        tbl[14] = '{0,0,0, 0,0,1,1};
        tbl[15] = '{1,1,0, 0,1,1,1};
        tbl[16] = '{1,1,0, 0,0,1,1};

        reset_n   = 1'b0;
        res_ready = 1'b0;
        idle();
        req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
        #2;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mult_x", mult_x, 0);
        chk("rst_res_id", res_id, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Single op: 1 * 1.
        req0_valid = 1'b1;
        req0_x     = XW'(1);
        req0_y     = XW'(1);
        res_ready  = 1'b1;
        step();
        idle();
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (res_valid && first == 0) begin
                first = i;
                chk("single_p", res_p, 1);
                chk("single_id", res_id, 0);
            end
        end
        chk("single_latency", first, 3);
        chk("single_busy_end", busy, 0);

        // Table: contention, backpressure, full-with-pop, accept+pop.
        do_reset();
        tbl_on = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cur        = tbl[i];
            req0_valid = cur.v0;
            req1_valid = cur.v1;
            res_ready  = cur.rr;
            req0_x     = XW'(i + 1);
            req0_y     = XW'(2);
            req1_x     = XW'(i + 9);
            req1_y     = XW'(3);
            step();
        end
        tbl_on = 1'b0;
        idle();
        res_ready = 1'b1;
        repeat (20) step();

        // Reset with one result buffered and two in flight.
        res_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_x     = XW'(7);
        step();
        idle();
        repeat (2) step();
        req0_valid = 1'b1;
        step();
        step();
        reset_n    = 1'b0;
        req1_valid = 1'b1;
        #1;
        chk("mid_rst_ready0", req0_ready, 0);
        chk("mid_rst_ready1", req1_ready, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_res_id", res_id, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mult_x", mult_x, 0);
        chk("mid_rst_mult_y", mult_y, 0);
        do_reset();
        res_ready = 1'b1;
        repeat (6) step();

        // Random traffic against the model.
        for (int i = 0; i < 10000; i++) begin
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            req0_x     = XW'($urandom);
            req0_y     = XW'($urandom);
            req1_x     = XW'($urandom);
            req1_y     = XW'($urandom);
            res_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        res_ready = 1'b1;
        repeat (20) step();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
